// File: rtl/add_sub_pkg.sv
// add_sub_pkg: default adder width and add/subtract mode encodings
package add_sub_pkg;
  localparam int ADD_SUB_W = 64;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder (a, b, cin -> s, cout)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/n_bit_adder.sv
// n_bit_adder: registered ripple-carry add/sub (clk, rst_n, inp1, inp2, car_in, in_valid -> ans, car_out, overflow, out_valid)
module n_bit_adder
  import add_sub_pkg::*;
#(
  parameter int N = ADD_SUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  input  logic         car_in,
  input  logic         in_valid,
  output logic [N-1:0] ans,
  output logic         car_out,
  output logic         overflow,
  output logic         out_valid
);
  logic         sub;
  logic [N-1:0] b_eff, s;
  logic [N:0]   c;
  assign sub = (car_in == MODE_SUB);
  assign b_eff = inp2 ^ {N{sub}};
  assign c[0] = car_in;
  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (.a(inp1[i]), .b(b_eff[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans <= '0;
      car_out <= 1'b0;
      overflow <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ans <= s;
        car_out <= c[N];
        overflow <= c[N] ^ c[N-1];
      end
    end
  end
endmodule

// File: tb/tb_n_bit_adder.sv
// tb_n_bit_adder: table-driven and scoreboarded check of n_bit_adder
module tb_n_bit_adder;
  typedef struct {
    logic [63:0] ans;
    logic        co;
    logic        ov;
  } res_t;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        m;
    res_t        r;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] inp1 = '0, inp2 = '0;
  logic        car_in = 1'b0, in_valid = 1'b0;
  logic [63:0] ans;
  logic        car_out, overflow, out_valid;
  int          checks = 0, errors = 0;
  res_t        q[$];
  res_t        hold = '{64'd0, 1'b0, 1'b0};
  vec_t        tbl[6];
  n_bit_adder #(.N(64)) dut (
    .clk(clk), .rst_n(rst_n), .inp1(inp1), .inp2(inp2), .car_in(car_in),
    .in_valid(in_valid), .ans(ans), .car_out(car_out), .overflow(overflow),
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic m);
    res_t        r;
    logic [63:0] be;
    logic [64:0] t;
    be = b ^ {64{m}};
    t = {1'b0, a} + {1'b0, be} + 65'(m);
    r.ans = t[63:0];
    r.co = t[64];
    r.ov = (a[63] == be[63]) && (t[63] != a[63]);
    return r;
  endfunction
  task automatic cmp_res(input string name, input res_t e);
    checks++;
    if (ans !== e.ans || car_out !== e.co || overflow !== e.ov) begin
      errors++;
      $display("FAIL %s: got ans=%h co=%b ov=%b want ans=%h co=%b ov=%b",
               name, ans, car_out, overflow, e.ans, e.co, e.ov);
    end
  endtask
  task automatic cmp_valid(input string name, input logic e);
    checks++;
    if (out_valid !== e) begin
      errors++;
      $display("FAIL %s: got out_valid=%b want %b", name, out_valid, e);
    end
  endtask
  task automatic apply(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic m, input logic v, input res_t e);
    inp1 = a;
    inp2 = b;
    car_in = m;
    in_valid = v;
    if (v) q.push_back(e);
    @(posedge clk);
    #1;
    cmp_valid(name, v);
    if (v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty got ans=%h want an entry", name, ans);
      end else begin
        hold = q.pop_front();
        cmp_res(name, hold);
      end
    end else cmp_res({name, "_hold"}, hold);
  endtask
  initial begin
    tbl[0] = '{64'd4321, 64'd1234, 1'b0, '{64'd5555, 1'b0, 1'b0}};
    tbl[1] = '{64'd4321, 64'd1234, 1'b1, '{64'd3087, 1'b1, 1'b0}};
    tbl[2] = '{64'd0, 64'd1, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0}};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, '{64'd0, 1'b1, 1'b0}};
    tbl[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, '{64'h8000_0000_0000_0000, 1'b0, 1'b1}};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}};
    #1;
    cmp_valid("reset_valid", 1'b0);
    cmp_res("reset_out", '{64'd0, 1'b0, 1'b0});
    inp1 = tbl[0].a;
    inp2 = tbl[0].b;
    in_valid = 1'b1;
    #11 rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      apply($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m, 1'b1, tbl[i].r);
    apply("idle0", 64'd7, 64'd9, 1'b0, 1'b0, hold);
    apply("idle1", 64'd3, 64'd3, 1'b1, 1'b0, hold);
    for (int i = 0; i < 20; i++) begin
      logic [63:0] a, b;
      logic m, v;
      a = {$urandom, $urandom};
      b = (i % 5 == 0) ? a : {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      v = (i % 4 != 3);
      apply($sformatf("rnd%0d", i), a, b, m, v, model(a, b, m));
    end
    inp1 = 64'd100;
    inp2 = 64'd50;
    car_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp_valid("async_rst_valid", 1'b0);
    cmp_res("async_rst_out", '{64'd0, 1'b0, 1'b0});
    hold = '{64'd0, 1'b0, 1'b0};
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply("post_rst_idle", 64'd1, 64'd1, 1'b0, 1'b0, hold);
    apply("post_rst_op", 64'd10, 64'd20, 1'b1, 1'b1, model(64'd10, 64'd20, 1'b1));
    apply("final_idle", 64'd0, 64'd0, 1'b0, 1'b0, hold);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/n_bit_adder.md
# n_bit_adder

Parameterised two's-complement adder/subtractor, 64 bits wide by default, with a registered result stage. The `car_in` mode bit selects A+B or A−B. The block provides sum/difference, carry-out and signed overflow one clock after the operands are sampled. It sits in the datapath as a general arithmetic primitive feeding ALU-level logic.

## Interface
Parameters:
- `N`, default 64: operand and result width in bits; legal values are N ≥ 2.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `inp1`  in  N  operand A.
- `inp2`  in  N  operand B.
- `car_in`  in  1  mode select: 0 computes A+B, 1 computes A−B (A + ~B + 1).
- `in_valid`  in  1  operands and mode are sampled when high at the clock edge.
- `ans`  out  N  registered result, modulo 2^N.
- `car_out`  out  1  registered carry out of bit N−1.
- `overflow`  out  1  registered signed overflow flag.
- `out_valid`  out  1  high for one cycle when `ans`, `car_out` and `overflow` hold a fresh result.

## Operation
- Effective B operand: `b_eff = inp2 XOR {N{car_in}}`. Carry into bit 0 is `car_in`.
- The adder is a ripple-carry chain of N full adders:
  - `s[i] = a[i] ^ b_eff[i] ^ c[i]`
  - `c[i+1] = majority(a[i], b_eff[i], c[i])`
  - `c[0] = car_in`
- `car_out = c[N]`.
  - Add mode: unsigned carry.
  - Subtract mode: 1 means no borrow (A ≥ B unsigned), 0 means a borrow occurred.
- `overflow = c[N] ^ c[N−1]`. This equals signed two's-complement overflow in both modes.
- Results wrap modulo 2^N. No saturation is applied.
- When `in_valid` is low at a clock edge:
  - `ans`, `car_out` and `overflow` hold their previous values.
  - `out_valid` goes to 0.
- The block has no backpressure. A new operation can be accepted every cycle.

## Timing
- Reset (`rst_n` low, asynchronous): `ans` = 0, `car_out` = 0, `overflow` = 0, `out_valid` = 0. These values take effect immediately, without waiting for a clock edge.
- Deassertion of reset is sampled on the next rising edge of `clk`. An `in_valid` pulse on that first edge is accepted.
- Latency is 1 cycle. Operands sampled at edge k appear on the outputs after edge k, with `out_valid` = 1 during cycle k+1.
- Throughput is 1 operation per cycle. Back-to-back `in_valid` produces back-to-back `out_valid`, and each result corresponds to its own sampled inputs.
- Reset asserted mid-operation discards the in-flight result. `out_valid` is 0 after reset.
- The combinational path is the N-bit ripple chain. The timing budget is the full clock period from `inp1`/`inp2`/`car_in` to the output registers.

## Structure
- Shared package `add_sub_pkg`:
  - constant `ADD_SUB_W = 64`, the default width;
  - mode constants `MODE_ADD = 1'b0` and `MODE_SUB = 1'b1`.
- Sub-module `full_adder` (inputs a, b, cin; outputs s, cout) is instantiated N times in a generate loop.
- The top-level contains:
  - the B-inversion XOR;
  - the carry-chain generate loop;
  - the overflow XOR;
  - the output/valid registers with asynchronous reset.

## Test plan
- Add: A=4321, B=1234, car_in=0, in_valid=1 → next cycle ans=5555, car_out=0, overflow=0, out_valid=1.
- Subtract: A=4321, B=1234, car_in=1 → ans=3087, car_out=1, overflow=0.
- Wrap/borrow: A=0, B=1, car_in=1 → ans=0xFFFF_FFFF_FFFF_FFFF, car_out=0, overflow=0. Also A=all-ones, B=1, car_in=0 → ans=0, car_out=1, overflow=0.
- Signed overflow, both directions:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=1, add → ans=0x8000_0000_0000_0000, overflow=1, car_out=0.
  - A=0x8000_0000_0000_0000, B=1, subtract → ans=0x7FFF_FFFF_FFFF_FFFF, overflow=1, car_out=1.
- Hold and streaming:
  - three back-to-back valid operations produce three consecutive correct results with out_valid=1;
  - dropping in_valid holds the last ans and clears out_valid.
- Asynchronous reset: assert rst_n=0 between clock edges while a result is pending → all outputs are 0 immediately, and out_valid stays 0 until the next valid input after release.
